// File: rtl/parking_meter_pkg.sv
// Shared encodings and constants for the parking meter command sequencer.
// Times are four packed BCD digits {thousands, hundreds, tens, ones}.
package parking_meter_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_DEC    = 2'd1,
    OP_PRESET = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    DISP_ZERO   = 2'd0,
    DISP_LOW    = 2'd1,
    DISP_NORMAL = 2'd2
  } disp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Request bit positions in the pending vector.
  localparam int RQ_ADD1 = 0;
  localparam int RQ_ADD2 = 1;
  localparam int RQ_ADD3 = 2;
  localparam int RQ_ADD4 = 3;
  localparam int RQ_RST1 = 4;
  localparam int RQ_RST2 = 5;
  localparam int NUM_RQ  = 6;

  localparam logic [NUM_RQ-1:0] ADD_MASK = 6'b001111;

  localparam logic [15:0] ADD_60      = 16'h0060;
  localparam logic [15:0] ADD_120     = 16'h0120;
  localparam logic [15:0] ADD_180     = 16'h0180;
  localparam logic [15:0] ADD_300     = 16'h0300;
  localparam logic [15:0] PRESET_0016 = 16'h0016;
  localparam logic [15:0] PRESET_0150 = 16'h0150;
  localparam logic [15:0] LOW_LIMIT   = 16'h0180;

  // Packed BCD orders the same way as binary, so a plain compare works.
  function automatic disp_e disp_of(input logic [15:0] t);
    if (t == 16'h0000)
      return DISP_ZERO;
    else if (t < LOW_LIMIT)
      return DISP_LOW;
    else
      return DISP_NORMAL;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw button level followed by a one-cycle
// rising-edge pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking keeps this a true three-stage shift; blocking
      // would collapse it into a single flop.
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/parking_meter_ctrl.sv
// Parking meter sequencer: arbitrates button requests and the 1 s tick onto
// a digit-serial BCD add/decrement engine that owns the committed time.
module parking_meter_ctrl
  import parking_meter_pkg::*;
#(
  parameter int          TICK_DIV = 100,
  parameter logic [15:0] SAT_VAL  = 16'h9999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add1,
  input  logic       add2,
  input  logic       add3,
  input  logic       add4,
  input  logic       rst1,
  input  logic       rst2,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic       busy,
  output logic [1:0] disp_mode,
  output logic       sec_phase
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NUM_RQ-1:0] raw_v, edge_v, pend, pend_clr;
  logic [PW-1:0]     presc;
  logic              wrap, tick_pend, tick_clr, presc_clr;

  state_e      state, state_nxt;
  op_e         mode, gnt_op;
  logic        gnt_go, gnt_load;
  logic [15:0] gnt_addend, gnt_preset;

  logic [15:0] dig, w, a, w_upd;
  logic [1:0]  idx;
  logic        c, c_nxt;
  logic [3:0]  w_dig, a_dig, r_dig;
  logic [4:0]  sum, sum_adj;

  assign raw_v = {rst2, rst1, add4, add3, add2, add1};

  for (genvar i = 0; i < NUM_RQ; i++) begin : g_sync
    btn_edge_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_v[i]),
      .pulse (edge_v[i])
    );
  end

  assign wrap = (presc == PW'(TICK_DIV - 1));

  // A clear on the grant edge wins over a new edge or wrap on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      tick_pend <= 1'b0;
      presc     <= '0;
      sec_phase <= 1'b0;
    end else begin
      pend      <= (pend | edge_v) & ~pend_clr;
      tick_pend <= (tick_pend | wrap) & ~tick_clr;
      presc     <= (presc_clr || wrap) ? '0 : presc + PW'(1);
      sec_phase <= sec_phase ^ wrap;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch
    // can leave a value held and infer a latch.
    state_nxt  = state;
    gnt_go     = 1'b0;
    gnt_load   = 1'b0;
    gnt_op     = OP_ADD;
    gnt_addend = '0;
    gnt_preset = '0;
    pend_clr   = '0;
    tick_clr   = 1'b0;
    presc_clr  = 1'b0;
    if (state == ST_IDLE) begin
      if (pend[RQ_RST1]) begin
        gnt_op = OP_PRESET; gnt_preset = PRESET_0016; pend_clr[RQ_RST1] = 1'b1;
      end else if (pend[RQ_RST2]) begin
        gnt_op = OP_PRESET; gnt_preset = PRESET_0150; pend_clr[RQ_RST2] = 1'b1;
      end else if (pend[RQ_ADD4]) begin
        gnt_go = 1'b1; gnt_addend = ADD_300; pend_clr[RQ_ADD4] = 1'b1;
      end else if (pend[RQ_ADD3]) begin
        gnt_go = 1'b1; gnt_addend = ADD_180; pend_clr[RQ_ADD3] = 1'b1;
      end else if (pend[RQ_ADD2]) begin
        gnt_go = 1'b1; gnt_addend = ADD_120; pend_clr[RQ_ADD2] = 1'b1;
      end else if (pend[RQ_ADD1]) begin
        gnt_go = 1'b1; gnt_addend = ADD_60;  pend_clr[RQ_ADD1] = 1'b1;
      end else if (tick_pend) begin
        tick_clr = 1'b1;
        if (dig != 16'h0000) begin
          gnt_go = 1'b1; gnt_op = OP_DEC;
        end
      end
      // A preset restarts the second and discards queued additions.
      if (gnt_op == OP_PRESET) begin
        gnt_load  = 1'b1;
        pend_clr  = pend_clr | ADD_MASK;
        tick_clr  = 1'b1;
        presc_clr = 1'b1;
      end
      if (gnt_go) state_nxt = ST_RUN;
    end else if (idx == 2'd3) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // One BCD digit per cycle; c is the carry when adding, the borrow when
  // decrementing.
  assign w_dig   = w[{idx, 2'b00} +: 4];
  assign a_dig   = a[{idx, 2'b00} +: 4];
  assign sum     = {1'b0, w_dig} + {1'b0, a_dig} + {4'b0000, c};
  assign sum_adj = sum - 5'd10;

  always_comb begin
    r_dig = w_dig;
    c_nxt = 1'b0;
    if (mode == OP_ADD) begin
      if (sum > 5'd9) begin
        r_dig = sum_adj[3:0]; c_nxt = 1'b1;
      end else begin
        r_dig = sum[3:0];
      end
    end else if (w_dig < {3'b000, c}) begin
      r_dig = 4'd9; c_nxt = 1'b1;
    end else begin
      r_dig = w_dig - {3'b000, c};
    end
    w_upd = w;
    w_upd[{idx, 2'b00} +: 4] = r_dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig  <= '0;
      w    <= '0;
      a    <= '0;
      c    <= 1'b0;
      idx  <= '0;
      mode <= OP_ADD;
    end else if (state == ST_IDLE) begin
      if (gnt_load) begin
        dig <= gnt_preset;
      end else if (gnt_go) begin
        w    <= dig;
        a    <= gnt_addend;
        c    <= (gnt_op == OP_DEC);
        idx  <= '0;
        mode <= gnt_op;
      end
    end else begin
      w   <= w_upd;
      c   <= c_nxt;
      idx <= idx + 2'd1;
      if (idx == 2'd3)
        dig <= (mode == OP_ADD && c_nxt) ? SAT_VAL : w_upd;
    end
  end

  assign {dig4, dig3, dig2, dig1} = dig;
  assign busy      = (state == ST_RUN);
  assign disp_mode = disp_of(dig);

endmodule

// File: doc/parking_meter_ctrl.md
# parking_meter_ctrl

Command sequencer and BCD time keeper for the parking meter. Six button levels (add1–add4, rst1, rst2) pass through synchronizers and edge detectors into pending-request bits. The block arbitrates those bits, plus a 1 s countdown tick, onto a single digit-serial BCD add/decrement engine. Its committed four-digit BCD time feeds the seven-segment driver and BCD output encoder, and replaces the ad-hoc per-button digit arithmetic.

## Interface
Parameters:
- TICK_DIV, 100: clock cycles per countdown second (100 Hz clk gives 1 s).
- SAT_VAL, 9999: saturation value on add overflow, as four BCD digits.

Ports:
- clk  in  1  system clock (100 Hz nominal)
- rst  in  1  reset; asynchronous, active-high
- add1, add2, add3, add4  in  1 each  raw button levels: +60, +120, +180, +300 s
- rst1, rst2  in  1 each  raw preset buttons: load 0016, load 0150
- dig1..dig4  out  4 each  committed BCD time; dig1 = ones, dig4 = thousands
- busy  out  1  high while the engine runs an add or decrement
- disp_mode  out  2  0 = ZERO (time 0000), 1 = LOW (0001–0179), 2 = NORMAL (≥0180); combinational from dig1..dig4
- sec_phase  out  1  toggles on every tick; the display blinks from it

## Operation
- Input path, per button: 2-flop synchronizer, then rising-edge detect.
  - A detected edge sets that button's pending bit.
  - An edge on an already-pending button is dropped.
- Prescaler counts 0..TICK_DIV-1 and wraps.
  - Each wrap sets tick_pend and toggles sec_phase.
  - A wrap while tick_pend is already set is dropped.
- FSM states: IDLE, RUN.
- In IDLE, the grant takes the highest-priority pending request in this order: rst1 > rst2 > add4 > add3 > add2 > add1 > tick.
- Preset grant (rst1 or rst2):
  - dig loaded directly: 0016 or 0150.
  - All add pending bits and tick_pend cleared; prescaler cleared to 0.
  - FSM stays in IDLE.
- Add grant:
  - Latch the addend digits {d4,d3,d2,d1}: 60 = 0,0,6,0; 120 = 0,1,2,0; 180 = 0,1,8,0; 300 = 0,3,0,0.
  - Copy dig into the working register, clear the carry, set idx = 0, go to RUN.
  - Clear the granted pending bit.
- Tick grant:
  - Only when the time is nonzero; go to RUN in decrement mode.
  - If the time is 0000, tick_pend is cleared with no other effect.
- RUN processes one digit per cycle, idx 0..3.
  - Add: s = w[idx] + a[idx] + c. If s > 9, w = s − 10 and c = 1; otherwise w = s and c = 0.
  - Decrement: the borrow starts at 1. If w[idx] − b < 0, w = 9 and b = 1; otherwise w = w − b and b = 0.
  - After idx 3: commit the working register to dig, or SAT_VAL if the final carry is 1. Return to IDLE.
- Pending bits and the prescaler keep running during RUN. Requests arriving then are served in priority order afterwards.
- Digit width: 5-bit intermediate sum (max 9 + 9 + 1 = 19). Outputs are always valid BCD 0–9.

## Timing
- Reset values: dig1..dig4 = 0, busy = 0, sec_phase = 0, disp_mode = 0. All pending bits, prescaler, FSM (IDLE) and working register also clear.
- Raw rise sampled at edge k: pending bit set at edge k+2; earliest grant at edge k+3.
- Add or decrement granted at edge g:
  - busy = 1 from after edge g until edge g+4.
  - dig updates only at edge g+4, never with partial digits.
  - The next grant can occur at edge g+5.
- Preset granted at edge g: dig updates at edge g; busy stays 0.
- Simultaneous events at the same edge resolve by the priority order above. Losers stay pending.
- Reset asserted mid-RUN: immediate return to reset values; the partial result is discarded.

## Structure
- Shared package parking_meter_pkg holds:
  - op encoding: OP_ADD, OP_DEC, OP_PRESET
  - addend digit constants (60/120/180/300) and preset constants (0016, 0150)
  - disp_mode codes ZERO/LOW/NORMAL
- One sub-module, btn_edge_sync (2-flop sync plus rising-edge pulse), instantiated six times.
- The digit adder/decrementer stays inline.

## Test plan
- Reset, then TICK_DIV = 8, no buttons → dig stays 0000, disp_mode = 0, sec_phase toggles every 8 cycles.
- rst2 pulse, then 3 ticks → 0150 → 0147; disp_mode = 1; busy high exactly 4 cycles per tick.
- rst2, then add3 → 0150 + 180 = 0330; disp_mode = 2; dig changes only at grant+4.
- Preset 9950, then add4 → saturates at 9999. From 0016, 16 ticks → 0000; a 17th tick leaves 0000.
- add1 and add4 rise on the same cycle, with a tick pending → add4 first, then add1, then the tick. From 0100, the sequence is 0400, 0460, 0459.
- Assert rst two cycles into an add → all outputs are 0 on the following cycle; the pending add is lost.
